// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if
//   Bundles the load/convert handshake and the multiplexed display lines of
//   bcd_scan_display.
//   master : drives load, bin_in, dp_in, blank_lz, bright; observes status and display
//   slave  : the display block itself
//   Signals:
//     load      single-cycle convert request
//     bin_in    binary value to convert (BIN_W bits)
//     dp_in     decimal-point mask, bit i = digit i
//     blank_lz  1 = blank leading zeros
//     bright    per-slot on-time, 0 = dimmest, all-ones = full
//     busy      conversion in progress
//     ovf       committed value does not fit in DIGITS decimal digits
//     seg       segments a..g (bit0 = a), active high
//     dp        decimal point, active high
//     an        digit enables, one-hot active low, bit 0 = rightmost digit
interface bcd_scan_display_if #(
    parameter int BIN_W    = 12,
    parameter int DIGITS   = 4,
    parameter int BRIGHT_W = 3
);
    logic                load;
    logic [BIN_W-1:0]    bin_in;
    logic [DIGITS-1:0]   dp_in;
    logic                blank_lz;
    logic [BRIGHT_W-1:0] bright;
    logic                busy;
    logic                ovf;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;

    modport master (
        output load, bin_in, dp_in, blank_lz, bright,
        input  busy, ovf, seg, dp, an
    );

    modport slave (
        input  load, bin_in, dp_in, blank_lz, bright,
        output busy, ovf, seg, dp, an
    );
endinterface

// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   Converts a binary value to BCD with a sequential double-dabble engine
//   (one bit per clock) and scans the result onto a DIGITS-wide multiplexed
//   common-anode 7-segment display with overflow dashes, leading-zero
//   blanking, per-digit decimal points and PWM brightness.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous reset, active low
//     bus    bcd_scan_display_if.slave (load/bin_in/dp_in/blank_lz/bright in,
//            busy/ovf/seg/dp/an out)
module bcd_scan_display #(
    parameter int BIN_W    = 12,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 12000,
    parameter int BRIGHT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_scan_display_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int LIM_W = PRE_W + BRIGHT_W + 2;
    localparam logic [LIM_W-1:0] SLOT_UNIT = LIM_W'(SCAN_DIV >> BRIGHT_W);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Converter state
    logic [0:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [BIN_W-1:0]  data_r;
    logic [BCD_W-1:0]  scratch_r;
    logic              ovf_scr_r;
    logic [DIGITS-1:0] dp_cap_r;

    // Committed display contents
    logic [BCD_W-1:0]  disp_r;
    logic [DIGITS-1:0] dp_reg_r;
    logic              ovf_r;

    // Scan state and registered outputs
    logic [PRE_W-1:0]  presc_r;
    logic [IDX_W-1:0]  idx_r;
    logic [6:0]        seg_r;
    logic              dp_r;
    logic [DIGITS-1:0] an_r;

    // Combinational helpers
    logic [BCD_W-1:0]  adj_s;
    logic [BCD_W-1:0]  scr_nx_s;
    logic [BIN_W-1:0]  data_nx_s;
    logic              carry_s;
    logic [3:0]        nib_s;
    logic              dp_sel_s;
    logic              blank_s;
    logic              zero_above_s;
    logic [LIM_W-1:0]  lim_s;
    logic              on_s;
    logic [6:0]        seg_nx_s;
    logic [DIGITS-1:0] an_nx_s;
    logic              dp_nx_s;

    function automatic logic [6:0] seg7_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h3F;  // A..F are unreachable; show them as 0
        endcase
        return s;
    endfunction

    // Double-dabble adjust: every nibble >= 5 gets +3 before the shift
    always_comb begin
        adj_s = scratch_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_r[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = scratch_r[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = scratch_r[4*i +: 4];
            end
        end
    end

    // The bit leaving the top nibble means the value needs more than DIGITS digits
    assign {carry_s, scr_nx_s, data_nx_s} = {adj_s, data_r, 1'b0};

    // Converter FSM: capture on load, BIN_W shift cycles, then commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            data_r    <= {BIN_W{1'b0}};
            scratch_r <= {BCD_W{1'b0}};
            ovf_scr_r <= 1'b0;
            dp_cap_r  <= {DIGITS{1'b0}};
            disp_r    <= {BCD_W{1'b0}};
            dp_reg_r  <= {DIGITS{1'b0}};
            ovf_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.load) begin
                        data_r    <= bus.bin_in;
                        dp_cap_r  <= bus.dp_in;
                        scratch_r <= {BCD_W{1'b0}};
                        ovf_scr_r <= 1'b0;
                        cnt_r     <= CNT_W'(BIN_W);
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch_r <= scr_nx_s;
                    data_r    <= data_nx_s;
                    ovf_scr_r <= ovf_scr_r | carry_s;
                    cnt_r     <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        disp_r   <= scr_nx_s;
                        ovf_r    <= ovf_scr_r | carry_s;
                        dp_reg_r <= dp_cap_r;
                        state_r  <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Prescaler and digit index for the multiplex scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PRE_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
        end else if (presc_r == PRE_W'(SCAN_DIV - 1)) begin
            presc_r <= {PRE_W{1'b0}};
            idx_r   <= (idx_r == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    // Select the scanned nibble; a digit is a leading zero if it and all above are zero
    always_comb begin
        nib_s        = 4'd0;
        dp_sel_s     = 1'b0;
        blank_s      = 1'b0;
        zero_above_s = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above_s = zero_above_s & (disp_r[4*i +: 4] == 4'd0);
            nib_s    = (idx_r == IDX_W'(i)) ? disp_r[4*i +: 4] : nib_s;
            dp_sel_s = (idx_r == IDX_W'(i)) ? dp_reg_r[i] : dp_sel_s;
            blank_s  = (idx_r == IDX_W'(i)) ? (zero_above_s && (i != 0)) : blank_s;
        end
    end

    // PWM window: digit lit for the first (bright+1) units of each slot
    assign lim_s = (LIM_W'(bus.bright) + LIM_W'(1)) * SLOT_UNIT;
    assign on_s  = (LIM_W'(presc_r) < lim_s);

    // Next segment pattern: dark, dashes on overflow, blanked, or decoded digit
    always_comb begin
        if (!on_s) begin
            seg_nx_s = 7'h00;
        end else if (ovf_r) begin
            seg_nx_s = 7'h40;
        end else if (bus.blank_lz && blank_s) begin
            seg_nx_s = 7'h00;
        end else begin
            seg_nx_s = seg7_decode(nib_s);
        end
    end

    assign an_nx_s = on_s ? ~(DIGITS'(1) << idx_r) : {DIGITS{1'b1}};
    assign dp_nx_s = on_s & dp_sel_s;

    // Display output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= 7'h00;
            dp_r  <= 1'b0;
            an_r  <= {DIGITS{1'b1}};
        end else begin
            seg_r <= seg_nx_s;
            dp_r  <= dp_nx_s;
            an_r  <= an_nx_s;
        end
    end

    assign bus.busy = (state_r == ST_SHIFT);
    assign bus.ovf  = ovf_r;
    assign bus.seg  = seg_r;
    assign bus.dp   = dp_r;
    assign bus.an   = an_r;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display
//   Drives a 4-digit and a 3-digit instance from the same stimulus and
//   compares every cycle against an arithmetic model of the display.
module tb_bcd_scan_display;

    localparam int BIN_W = 12;
    localparam int SD    = 16;
    localparam int BW    = 2;

    localparam logic [6:0] SEGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam int PICKS [8] = '{0, 9, 10, 99, 100, 999, 1000, 4095};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             load     = 1'b0;
    logic [BIN_W-1:0] bin_in   = 12'd0;
    logic [3:0]       dp_in    = 4'd0;
    logic             blank_lz = 1'b0;
    logic [BW-1:0]    bright   = 2'd3;

    bcd_scan_display_if #(.BIN_W(BIN_W), .DIGITS(4), .BRIGHT_W(BW)) bus4 ();
    bcd_scan_display_if #(.BIN_W(BIN_W), .DIGITS(3), .BRIGHT_W(BW)) bus3 ();

    assign bus4.load = load;     assign bus3.load = load;
    assign bus4.bin_in = bin_in; assign bus3.bin_in = bin_in;
    assign bus4.dp_in = dp_in;   assign bus3.dp_in = dp_in[2:0];
    assign bus4.blank_lz = blank_lz; assign bus3.blank_lz = blank_lz;
    assign bus4.bright = bright; assign bus3.bright = bright;

    bcd_scan_display #(.BIN_W(BIN_W), .DIGITS(4), .SCAN_DIV(SD), .BRIGHT_W(BW)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4));
    bcd_scan_display #(.BIN_W(BIN_W), .DIGITS(3), .SCAN_DIV(SD), .BRIGHT_W(BW)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int k;             // edges since reset release
    bit m_busy;
    int m_commit;
    int m_pend_val, m_pend_dp;
    int m_val, m_dp;
    bit m_ovf4, m_ovf3;

    task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s edge %0d: got %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Expected {dp, an(4), seg} for a d-digit display in scan position kk
    function automatic logic [11:0] exp_disp(input int d, input int kk, input int val,
                                             input bit ov, input int dpm, input bit blz,
                                             input int br);
        int phase, slot, p10, digit, mask;
        logic [6:0] s;
        logic [3:0] a;
        logic       dpo;
        phase = kk % SD;
        slot  = (kk / SD) % d;
        p10   = 1;
        for (int j = 0; j < slot; j++) p10 = p10 * 10;
        digit = (val / p10) % 10;
        mask  = (1 << d) - 1;
        if (phase >= (br + 1) * (SD / (1 << BW))) return {1'b0, 4'(mask), 7'h00};
        a = 4'(mask & ~(1 << slot));
        if (ov) s = 7'h40;
        else if (blz && slot > 0 && val < p10) s = 7'h00;
        else s = SEGS[digit];
        dpo = ((dpm >> slot) & 1) != 0;
        return {dpo, a, s};
    endfunction

    task automatic model_reset();
        k = 0; m_busy = 1'b0; m_commit = 0; m_pend_val = 0; m_pend_dp = 0;
        m_val = 0; m_dp = 0; m_ovf4 = 1'b0; m_ovf3 = 1'b0;
    endtask

    // One clock: predict, advance model on the edge, compare at the falling edge
    task automatic tick();
        logic [11:0] e4, e3;
        e4 = exp_disp(4, k, m_val, m_ovf4, m_dp, blank_lz, int'(bright));
        e3 = exp_disp(3, k, m_val, m_ovf3, m_dp & 7, blank_lz, int'(bright));
        @(posedge clk);
        if (m_busy) begin
            if (k == m_commit) begin
                m_busy = 1'b0;
                m_val  = m_pend_val;
                m_dp   = m_pend_dp;
                m_ovf4 = (m_val >= 10000);
                m_ovf3 = (m_val >= 1000);
            end
        end else if (load) begin
            m_busy     = 1'b1;
            m_commit   = k + BIN_W;
            m_pend_val = int'(bin_in);
            m_pend_dp  = int'(dp_in);
        end
        @(negedge clk);
        load = 1'b0;
        check_vec("dut4", {2'b00, bus4.busy, bus4.ovf, bus4.dp, bus4.an, bus4.seg},
                  {2'b00, m_busy, m_ovf4, e4});
        check_vec("dut3", {2'b00, bus3.busy, bus3.ovf, bus3.dp, 1'b0, bus3.an, bus3.seg},
                  {2'b00, m_busy, m_ovf3, e3});
        k++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int v, input int dpm);
        load   = 1'b1;
        bin_in = 12'(v);
        dp_in  = 4'(dpm);
        tick();
    endtask

    // Asynchronous reset between clock edges, then release on a falling edge
    task automatic do_reset(input int hold);
        #1 rst_n = 1'b0;
        load = 1'b0;
        #1;
        check_vec("rst4", {2'b00, bus4.busy, bus4.ovf, bus4.dp, bus4.an, bus4.seg},
                  {2'b00, 1'b0, 1'b0, 1'b0, 4'b1111, 7'h00});
        check_vec("rst3", {2'b00, bus3.busy, bus3.ovf, bus3.dp, 1'b0, bus3.an, bus3.seg},
                  {2'b00, 1'b0, 1'b0, 1'b0, 4'b0111, 7'h00});
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset(3);
        run(20);

        pulse(1234, 0);          run(80);
        bright = 2'd0;           run(64);
        bright = 2'd1;           run(64);
        bright = 2'd2;           run(64);
        bright = 2'd3;

        blank_lz = 1'b1;
        pulse(7, 0);             run(70);
        pulse(0, 0);             run(70);
        pulse(4005, 0);          run(70);
        blank_lz = 1'b0;

        pulse(1000, 0);          run(70);
        pulse(999, 0);           run(70);

        pulse(4095, 0);          run(4);
        pulse(1, 0);             run(70);

        run(30);                 // mid-scan
        pulse(123, 0);           run(5);
        do_reset(2);             run(70);

        pulse(2345, 4'b0010);    run(80);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(2);
            if ($urandom_range(0, 5) == 0) begin
                load   = 1'b1;
                bin_in = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 4095))
                                                     : 12'(PICKS[$urandom_range(0, 7)]);
                dp_in  = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) == 0) begin
                bright   = 2'($urandom_range(0, 3));
                blank_lz = 1'($urandom_range(0, 1));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
